// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide issue block: FSM states,
// operation encoding and default sizing.
package multdiv_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TAG_W   = 5;
  localparam int DEF_TIMEOUT = 40;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } mdState_t;

  // Counter width able to hold every value 0..timeout without wrapping.
  function automatic int cntWidth(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Wait-cycle counter for an outstanding multdiv operation. The count is 0 on
// the first enabled cycle, climbs once per enabled cycle and saturates
// instead of wrapping; expired marks the last allowed wait cycle.
module multdiv_watchdog
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = cntWidth(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Count wait cycles; clear wins over enable, and the count parks at CAP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CAP)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/multdiv_issue.sv
// Issue/writeback wrapper around a multi-cycle multiply/divide unit: accepts
// one request, fires a single start pulse, waits for completion (or a
// watchdog timeout) and holds the response until the writeback side takes it.
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_operandA,
  output logic [WIDTH-1:0] data_operandB,
  input  logic [WIDTH-1:0] data_result,
  input  logic             data_exception,
  input  logic             data_resultRDY,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_exception,
  output logic             rsp_timeout,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             stall,
  output logic             spurious_rdy
);

  mdState_t state, stateNext;

  logic             capReq;
  logic             expired;
  logic             inWait;
  logic             holdOperands;

  // Captured request and response. These are plain data registers without
  // reset: every output that exposes them is qualified by the FSM state,
  // so stale contents never reach the ports.
  logic             opQ;
  logic [WIDTH-1:0] aQ;
  logic [WIDTH-1:0] bQ;
  logic [TAG_W-1:0] tagQ;
  logic [WIDTH-1:0] resQ;
  logic             excQ;
  logic             toQ;
  logic             spuriousQ;

  assign inWait       = (state == WAIT);
  assign holdOperands = (state == LAUNCH) || inWait;

  multdiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) uWatchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!inWait),
    .enable  (inWait),
    .expired (expired)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    stateNext = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    stall     = 1'b0;
    capReq    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capReq    = 1'b1;
          stateNext = LAUNCH;
        end
      end
      LAUNCH: begin
        // Any data_resultRDY seen here belongs to nothing we launched.
        stall     = 1'b1;
        stateNext = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (data_resultRDY || expired) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        stall     = !rsp_ready;
        if (rsp_ready) begin
          // Response retires this cycle, so a new request can slip in.
          req_ready = 1'b1;
          if (req_valid) begin
            capReq    = 1'b1;
            stateNext = LAUNCH;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Request and response capture; a real result beats a same-cycle timeout.
  always_ff @(posedge clock) begin
    if (capReq) begin
      opQ  <= req_op;
      aQ   <= req_a;
      bQ   <= req_b;
      tagQ <= req_tag;
    end
    if (inWait) begin
      if (data_resultRDY) begin
        resQ <= data_result;
        excQ <= data_exception;
        toQ  <= 1'b0;
      end else if (expired) begin
        resQ <= '0;
        excQ <= 1'b1;
        toQ  <= 1'b1;
      end
    end
  end

  // Sticky flag for completions arriving when nothing is outstanding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spuriousQ <= 1'b0;
    end else if (data_resultRDY && ((state == IDLE) || (state == DONE))) begin
      spuriousQ <= 1'b1;
    end
  end

  // Start pulses come straight from the state so reset removes them at once.
  assign ctrl_MULT = (state == LAUNCH) && (opQ == OP_MULT);
  assign ctrl_DIV  = (state == LAUNCH) && (opQ == OP_DIV);

  assign data_operandA = holdOperands ? aQ : '0;
  assign data_operandB = holdOperands ? bQ : '0;

  assign rsp_result    = rsp_valid ? resQ : '0;
  assign rsp_exception = rsp_valid ? excQ : 1'b0;
  assign rsp_timeout   = rsp_valid ? toQ  : 1'b0;
  assign rsp_tag       = rsp_valid ? tagQ : '0;

  assign spurious_rdy  = spuriousQ;

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue: hand-built vector table, directed
// reset/spurious sequences, and randomized transactions checked against a
// simple transaction-level expectation model.
module tb_multdiv_issue;

  localparam int TIMEOUT = 40;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_exception;
  logic        rsp_timeout;
  logic [4:0]  rsp_tag;
  logic        stall;
  logic        spurious_rdy;

  int total = 0;
  int bad   = 0;
  int mulPulses = 0;
  int divPulses = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          delay;       // WAIT-cycle index at which the unit answers
    logic [31:0] ret;         // value the unit returns
    logic        retExc;
    int          hold;        // DONE cycles with rsp_ready low
    bit          spur;        // pulse data_resultRDY during those cycles
    bit          rdyInLaunch; // junk completion during the launch cycle
    logic [31:0] expRes;
    logic        expExc;
    logic        expTo;
  } txn_t;

  multdiv_issue #(
    .WIDTH   (32),
    .TAG_W   (5),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_tag        (req_tag),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_exception  (rsp_exception),
    .rsp_timeout    (rsp_timeout),
    .rsp_tag        (rsp_tag),
    .stall          (stall),
    .spurious_rdy   (spurious_rdy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count start pulses as seen mid-cycle.
  always @(negedge clock) begin
    if (ctrl_MULT) mulPulses <= mulPulses + 1;
    if (ctrl_DIV)  divPulses <= divPulses + 1;
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic txn_t mk(input logic op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] tag, input int delay, input logic [31:0] ret,
                              input logic retExc, input int hold, input bit spur,
                              input bit rdyInLaunch, input logic [31:0] expRes,
                              input logic expExc, input logic expTo);
    txn_t t;
    t.op = op; t.a = a; t.b = b; t.tag = tag; t.delay = delay;
    t.ret = ret; t.retExc = retExc; t.hold = hold; t.spur = spur;
    t.rdyInLaunch = rdyInLaunch;
    t.expRes = expRes; t.expExc = expExc; t.expTo = expTo;
    return t;
  endfunction

  // Reference: what an ideal multdiv unit returns, and what the response
  // must then be given how long the unit takes.
  function automatic txn_t randTxn();
    txn_t t;
    logic [63:0] prod;
    t.op  = 1'($urandom_range(0, 1));
    t.a   = $urandom;
    t.b   = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
    t.tag = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 7))
      0:       t.delay = TIMEOUT - 1;
      1:       t.delay = TIMEOUT + int'($urandom_range(0, 5));
      default: t.delay = int'($urandom_range(0, 8));
    endcase
    t.hold        = int'($urandom_range(0, 3));
    t.spur        = 1'($urandom_range(0, 1));
    t.rdyInLaunch = ($urandom_range(0, 3) == 0);
    if (t.op == 1'b0) begin
      prod     = 64'(t.a) * 64'(t.b);
      t.ret    = prod[31:0];
      t.retExc = 1'b0;
    end else if (t.b == 32'd0) begin
      t.ret    = 32'hFFFF_FFFF;
      t.retExc = 1'b1;
    end else begin
      t.ret    = t.a / t.b;
      t.retExc = 1'b0;
    end
    if (t.delay >= TIMEOUT) begin
      t.expRes = 32'd0; t.expExc = 1'b1; t.expTo = 1'b1;
    end else begin
      t.expRes = t.ret; t.expExc = t.retExc; t.expTo = 1'b0;
    end
    return t;
  endfunction

  // Drive one transaction end to end. Entered just after a rising edge with
  // the DUT idle (accepted=0) or already in LAUNCH (accepted=1). With
  // chain=1 the next request is offered in the retiring DONE cycle.
  task automatic runTxn(input txn_t t, input bit accepted, input bit chain, input txn_t nx);
    int m0, d0, dm, dd, lastK;
    if (!accepted) begin
      req_valid = 1'b1; req_op = t.op; req_a = t.a; req_b = t.b; req_tag = t.tag;
      @(negedge clock);
      chk("req_ready_idle", 128'(req_ready), 128'(1'b1));
      @(posedge clock); #1;
      req_valid = 1'b0;
    end
    m0 = mulPulses; d0 = divPulses;
    if (t.rdyInLaunch) begin
      data_resultRDY = 1'b1; data_result = 32'hDEAD_BEEF; data_exception = 1'b1;
    end
    @(negedge clock);
    chk("launch", {ctrl_MULT, ctrl_DIV, stall, req_ready, rsp_valid, data_operandA, data_operandB},
        {(t.op ? 2'b01 : 2'b10), 1'b1, 1'b0, 1'b0, t.a, t.b});
    @(posedge clock); #1;
    data_resultRDY = 1'b0; data_result = 32'd0; data_exception = 1'b0;
    lastK = (t.delay < TIMEOUT) ? t.delay : TIMEOUT - 1;
    for (int k = 0; k <= lastK; k++) begin
      if (k == t.delay) begin
        data_resultRDY = 1'b1; data_result = t.ret; data_exception = t.retExc;
      end
      @(negedge clock);
      chk("wait_hold", {rsp_valid, stall, req_ready, ctrl_MULT | ctrl_DIV, data_operandA, data_operandB},
          {1'b0, 1'b1, 1'b0, 1'b0, t.a, t.b});
      @(posedge clock); #1;
      data_resultRDY = 1'b0; data_result = 32'd0; data_exception = 1'b0;
    end
    for (int h = 0; h < t.hold; h++) begin
      rsp_ready = 1'b0;
      if (t.spur) begin
        data_resultRDY = 1'b1; data_result = 32'h1234_5678; data_exception = ~t.expExc;
      end
      @(negedge clock);
      chk("done_hold", {rsp_valid, stall, req_ready, rsp_result, rsp_exception, rsp_timeout, rsp_tag},
          {1'b1, 1'b1, 1'b0, t.expRes, t.expExc, t.expTo, t.tag});
      @(posedge clock); #1;
      data_resultRDY = 1'b0; data_result = 32'd0; data_exception = 1'b0;
    end
    rsp_ready = 1'b1;
    if (chain) begin
      req_valid = 1'b1; req_op = nx.op; req_a = nx.a; req_b = nx.b; req_tag = nx.tag;
    end
    @(negedge clock);
    chk("done_retire", {rsp_valid, stall, req_ready, rsp_result, rsp_exception, rsp_timeout, rsp_tag},
        {1'b1, 1'b0, 1'b1, t.expRes, t.expExc, t.expTo, t.tag});
    @(posedge clock); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    dm = mulPulses - m0; dd = divPulses - d0;
    chk("pulse_count", {dm[7:0], dd[7:0]}, t.op ? 16'h0001 : 16'h0100);
  endtask

  txn_t tbl[8];
  txn_t cur, nxt;
  bit   acc, ch;
  int   m0, d0, dm, dd;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
    data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0; rsp_ready = 1'b0;

    //      op    a             b      tag  delay      ret           exc  hold spur lnch expRes        expExc expTo
    tbl[0] = mk(1'b0, 32'd7,        32'd6,   5'd3,  4,          32'd42,       1'b0, 0, 0, 0, 32'd42,        1'b0, 1'b0);
    tbl[1] = mk(1'b1, 32'd10,       32'd0,   5'd9,  2,          32'hFFFFFFFF, 1'b1, 0, 0, 0, 32'hFFFFFFFF,  1'b1, 1'b0);
    tbl[2] = mk(1'b0, 32'd3,        32'd5,   5'd17, 1000,       32'd15,       1'b0, 0, 0, 0, 32'd0,         1'b1, 1'b1);
    tbl[3] = mk(1'b1, 32'd100,      32'd7,   5'd1,  TIMEOUT-1,  32'd14,       1'b0, 0, 0, 0, 32'd14,        1'b0, 1'b0);
    tbl[4] = mk(1'b0, 32'd2,        32'd8,   5'd30, 0,          32'd16,       1'b0, 0, 0, 1, 32'd16,        1'b0, 1'b0);
    tbl[5] = mk(1'b1, 32'd81,       32'd9,   5'd5,  1,          32'd9,        1'b0, 4, 1, 0, 32'd9,         1'b0, 1'b0);
    tbl[6] = mk(1'b0, 32'hFFFFFFFF, 32'd2,   5'd12, 3,          32'hFFFFFFFE, 1'b0, 0, 0, 0, 32'hFFFFFFFE,  1'b0, 1'b0);
    tbl[7] = mk(1'b1, 32'd50,       32'd5,   5'd13, 2,          32'd10,       1'b0, 0, 0, 0, 32'd10,        1'b0, 1'b0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_state", {req_ready, rsp_valid, stall, ctrl_MULT, ctrl_DIV, spurious_rdy,
                        data_operandA, data_operandB, rsp_result, rsp_exception, rsp_timeout, rsp_tag},
        {1'b1, 5'b0, 64'd0, 32'd0, 2'b0, 5'd0});
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      runTxn(tbl[i], 1'b0, 1'b0, tbl[i]);
      if (i == 4) chk("no_spurious_yet", 128'(spurious_rdy), 128'(1'b0));
    end
    chk("spurious_in_done", 128'(spurious_rdy), 128'(1'b1));

    // Back-to-back pair: second request accepted in the first one's DONE cycle.
    runTxn(tbl[6], 1'b0, 1'b1, tbl[7]);
    runTxn(tbl[7], 1'b1, 1'b0, tbl[7]);

    cur = randTxn();
    acc = 1'b0;
    for (int i = 0; i < 24; i++) begin
      nxt = randTxn();
      ch  = 1'($urandom_range(0, 1));
      runTxn(cur, acc, ch, nxt);
      acc = ch;
      cur = nxt;
    end
    runTxn(cur, acc, 1'b0, cur);

    // Reset while waiting: everything drops at once, nothing is reissued.
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd11; req_b = 32'd12; req_tag = 5'd7;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    m0 = mulPulses; d0 = divPulses;
    reset_n = 1'b0;
    #1;
    chk("reset_in_wait", {req_ready, rsp_valid, stall, ctrl_MULT, ctrl_DIV, spurious_rdy,
                          data_operandA, data_operandB},
        {1'b1, 5'b0, 64'd0});
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("after_reset", {rsp_valid, req_ready, stall, ctrl_MULT | ctrl_DIV}, 4'b0100);
      @(posedge clock); #1;
    end
    dm = mulPulses - m0; dd = divPulses - d0;
    chk("no_reissue", {dm[7:0], dd[7:0]}, 16'h0000);

    // Reset during the launch cycle removes the pulse without a clock edge.
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd9; req_b = 32'd3; req_tag = 5'd2;
    @(posedge clock); #1;
    req_valid = 1'b0;
    #1;
    chk("launch_pulse_up", {ctrl_MULT, ctrl_DIV}, 2'b01);
    reset_n = 1'b0;
    #1;
    chk("launch_pulse_drop", {ctrl_MULT, ctrl_DIV, req_ready}, 3'b001);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Completion with nothing outstanding.
    data_resultRDY = 1'b1; data_result = 32'h5555_5555;
    @(negedge clock);
    chk("idle_rdy_no_rsp", {rsp_valid, rsp_result, spurious_rdy}, {1'b0, 32'd0, 1'b0});
    @(posedge clock); #1;
    data_resultRDY = 1'b0; data_result = 32'd0;
    @(negedge clock);
    chk("spurious_in_idle", {spurious_rdy, rsp_valid, req_ready}, 3'b101);
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
